// File: rtl/rotary_decoder_mc.sv
// Multi-channel quadrature decoder: per-channel sync, debounce, Gray-step decode,
// detent pulses, bounded position counter and sticky illegal-transition flag.
module rotary_decoder_mc #(
    parameter int N_CH    = 2,
    parameter int STEPS   = 4,
    parameter int DEB_CYC = 16,
    parameter int POS_W   = 8,
    parameter int POS_MAX = 255,
    parameter int WRAP    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       a,
    input  logic [N_CH-1:0]       b,
    input  logic [N_CH-1:0]       clr,
    input  logic [N_CH-1:0]       err_clr,
    output logic [N_CH-1:0]       pulse_up,
    output logic [N_CH-1:0]       pulse_down,
    output logic [N_CH*POS_W-1:0] pos,
    output logic [N_CH-1:0]       err
);

    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int ACC_W = $clog2(STEPS + 1) + 1;
    localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(DEB_CYC - 1);
    localparam logic signed [ACC_W-1:0] ACC_POS   = ACC_W'(STEPS);
    localparam logic signed [ACC_W-1:0] ACC_NEG   = ACC_W'(-STEPS);
    localparam logic signed [ACC_W-1:0] ACC_ONE   = ACC_W'(1);
    localparam logic [POS_W-1:0]        POS_MAX_V = POS_W'(POS_MAX);

    typedef enum logic {ST_INIT, ST_TRACK} state_t;

    // Clockwise successor in {A,B} order: 00 -> 10 -> 11 -> 01 -> 00
    function automatic logic [1:0] cw_next(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [1:0]              sync1_reg, sync2_reg, filt_reg, prev_reg;
            logic [CNT_W-1:0]        deb_cnt_reg [2];
            logic [CNT_W-1:0]        init_cnt_reg;
            logic signed [ACC_W-1:0] acc_reg;
            logic [POS_W-1:0]        pos_reg;
            logic                    up_reg, down_reg, err_reg;
            state_t                  state_reg;

            logic                    moved, step_bad, step_cw, step_ccw;
            logic                    det_up, det_down;
            logic signed [ACC_W-1:0] acc_base;
            logic [POS_W-1:0]        pos_up_next, pos_down_next;

            assign moved    = (state_reg == ST_TRACK) && (filt_reg != prev_reg);
            assign step_bad = moved && (filt_reg == ~prev_reg);
            assign step_cw  = moved && (filt_reg == cw_next(prev_reg));
            assign step_ccw = moved && !step_bad && !step_cw;
            assign det_up   = (state_reg == ST_TRACK) && (acc_reg == ACC_POS);
            assign det_down = (state_reg == ST_TRACK) && (acc_reg == ACC_NEG);
            // A step landing on the detent cycle starts counting from zero
            assign acc_base = (det_up || det_down) ? '0 : acc_reg;

            assign pos_up_next = (pos_reg == POS_MAX_V) ?
                                 ((WRAP != 0) ? '0 : pos_reg) : pos_reg + POS_W'(1);
            assign pos_down_next = (pos_reg == '0) ?
                                   ((WRAP != 0) ? POS_MAX_V : pos_reg) : pos_reg - POS_W'(1);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg      <= '0;
                    sync2_reg      <= '0;
                    filt_reg       <= '0;
                    prev_reg       <= '0;
                    deb_cnt_reg[0] <= '0;
                    deb_cnt_reg[1] <= '0;
                    init_cnt_reg   <= '0;
                    acc_reg        <= '0;
                    pos_reg        <= '0;
                    up_reg         <= 1'b0;
                    down_reg       <= 1'b0;
                    err_reg        <= 1'b0;
                    state_reg      <= ST_INIT;
                end else begin
                    sync1_reg <= {a[gi], b[gi]};
                    sync2_reg <= sync1_reg;
                    up_reg    <= 1'b0;
                    down_reg  <= 1'b0;

                    for (int k = 0; k < 2; k++) begin
                        if (sync2_reg[k] != filt_reg[k]) begin
                            if (deb_cnt_reg[k] == CNT_LAST) begin
                                filt_reg[k]    <= sync2_reg[k];
                                deb_cnt_reg[k] <= '0;
                            end else begin
                                deb_cnt_reg[k] <= deb_cnt_reg[k] + CNT_W'(1);
                            end
                        end else begin
                            deb_cnt_reg[k] <= '0;
                        end
                    end

                    if (err_clr[gi])
                        err_reg <= 1'b0;

                    case (state_reg)
                        ST_INIT: begin
                            // Adopt the resting encoder position without decoding it
                            if (init_cnt_reg == CNT_LAST) begin
                                filt_reg       <= sync2_reg;
                                prev_reg       <= sync2_reg;
                                deb_cnt_reg[0] <= '0;
                                deb_cnt_reg[1] <= '0;
                                state_reg      <= ST_TRACK;
                            end else begin
                                init_cnt_reg <= init_cnt_reg + CNT_W'(1);
                            end
                        end
                        default: begin
                            if (moved)
                                prev_reg <= filt_reg;
                            if (det_up) begin
                                up_reg  <= 1'b1;
                                pos_reg <= pos_up_next;
                            end else if (det_down) begin
                                down_reg <= 1'b1;
                                pos_reg  <= pos_down_next;
                            end
                            if (step_bad) begin
                                acc_reg <= '0;
                                err_reg <= 1'b1;
                            end else if (step_cw) begin
                                acc_reg <= acc_base + ACC_ONE;
                            end else if (step_ccw) begin
                                acc_reg <= acc_base - ACC_ONE;
                            end else if (det_up || det_down) begin
                                acc_reg <= '0;
                            end
                        end
                    endcase

                    if (clr[gi]) begin
                        pos_reg <= '0;
                        acc_reg <= '0;
                    end
                end
            end

            assign pulse_up[gi]                 = up_reg;
            assign pulse_down[gi]               = down_reg;
            assign err[gi]                      = err_reg;
            assign pos[gi*POS_W +: POS_W]       = pos_reg;
        end
    endgenerate

endmodule

// File: tb/tb_rotary_decoder_mc.sv
// Directed bench for rotary_decoder_mc: a wrapping and a saturating instance
// share the same encoder stimulus; pulses are tallied and compared to hand counts.
module tb_rotary_decoder_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  a, b, clr, err_clr;
    logic [1:0]  up_w, dn_w, err_w, up_s, dn_s, err_s;
    logic [15:0] pos_w, pos_s;

    int checks = 0;
    int errors = 0;
    int up_cnt_w [2];
    int dn_cnt_w [2];
    int up_cnt_s [2];
    int dn_cnt_s [2];
    int eu [2];
    int ed [2];
    logic [1:0] cur_ab [2];

    always #5 clk = ~clk;

    rotary_decoder_mc #(.N_CH(2), .STEPS(4), .DEB_CYC(16), .POS_W(8), .POS_MAX(255), .WRAP(1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr), .err_clr(err_clr),
        .pulse_up(up_w), .pulse_down(dn_w), .pos(pos_w), .err(err_w)
    );

    rotary_decoder_mc #(.N_CH(2), .STEPS(4), .DEB_CYC(16), .POS_W(8), .POS_MAX(255), .WRAP(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr), .err_clr(err_clr),
        .pulse_up(up_s), .pulse_down(dn_s), .pos(pos_s), .err(err_s)
    );

    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (up_w[ch]) up_cnt_w[ch]++;
            if (dn_w[ch]) dn_cnt_w[ch]++;
            if (up_s[ch]) up_cnt_s[ch]++;
            if (dn_s[ch]) dn_cnt_s[ch]++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] s0, input logic [7:0] s1, input logic [1:0] e);
        check_eq({tag, " pos_w0"}, pos_w[7:0], w0);
        check_eq({tag, " pos_w1"}, pos_w[15:8], w1);
        check_eq({tag, " pos_s0"}, pos_s[7:0], s0);
        check_eq({tag, " pos_s1"}, pos_s[15:8], s1);
        check_eq({tag, " err_w"}, err_w, e);
        check_eq({tag, " err_s"}, err_s, e);
        for (int ch = 0; ch < 2; ch++) begin
            check_eq($sformatf("%s up_w%0d", tag, ch), up_cnt_w[ch], eu[ch]);
            check_eq($sformatf("%s dn_w%0d", tag, ch), dn_cnt_w[ch], ed[ch]);
            check_eq($sformatf("%s up_s%0d", tag, ch), up_cnt_s[ch], eu[ch]);
            check_eq($sformatf("%s dn_s%0d", tag, ch), dn_cnt_s[ch], ed[ch]);
        end
        $display("[tb] %-10s pos_w=%0d/%0d pos_s=%0d/%0d err=%b/%b checks=%0d",
                 tag, pos_w[7:0], pos_w[15:8], pos_s[7:0], pos_s[15:8], err_w, err_s, checks);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] cw_n(input logic [1:0] x);
        case (x)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] ccw_n(input logic [1:0] x);
        case (x)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // d0/d1: +1 CW step, -1 CCW step, 0 hold, 2 illegal double-bit jump
    task automatic step2(input int d0, input int d1, input int hold);
        for (int ch = 0; ch < 2; ch++) begin
            int d;
            d = (ch == 0) ? d0 : d1;
            if (d == 1)       cur_ab[ch] = cw_n(cur_ab[ch]);
            else if (d == -1) cur_ab[ch] = ccw_n(cur_ab[ch]);
            else if (d == 2)  cur_ab[ch] = ~cur_ab[ch];
            a[ch] = cur_ab[ch][1];
            b[ch] = cur_ab[ch][0];
        end
        if (hold > 0) wait_cyc(hold);
    endtask

    initial begin
        rst_n = 1'b0; a = 2'b11; b = 2'b11; clr = 2'b00; err_clr = 2'b00;
        cur_ab[0] = 2'b11; cur_ab[1] = 2'b11;
        for (int ch = 0; ch < 2; ch++) begin eu[ch] = 0; ed[ch] = 0; end

        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(18);
        check_all("reset", 0, 0, 0, 0, 2'b00);
        wait_cyc(20);
        check_all("settle", 0, 0, 0, 0, 2'b00);

        for (int i = 0; i < 4; i++) step2(1, 0, 40);
        eu[0]++;
        check_all("cw_detent", 1, 0, 1, 0, 2'b00);

        for (int i = 0; i < 3; i++) step2(1, 0, 40);
        for (int i = 0; i < 3; i++) step2(-1, 0, 40);
        check_all("reverse", 1, 0, 1, 0, 2'b00);
        for (int i = 0; i < 3; i++) step2(1, 0, 40);
        check_all("partial", 1, 0, 1, 0, 2'b00);
        step2(1, 0, 40);
        eu[0]++;
        check_all("acc_zero", 2, 0, 2, 0, 2'b00);

        for (int i = 0; i < 4; i++) begin
            a[0] = ~a[0]; wait_cyc(5);
            a[0] = ~a[0]; wait_cyc(5);
        end
        wait_cyc(30);
        check_all("glitch", 2, 0, 2, 0, 2'b00);

        for (int n = 0; n < 253; n++)
            for (int i = 0; i < 4; i++) step2(1, 0, 22);
        wait_cyc(20);
        eu[0] += 253;
        check_all("to_max", 255, 0, 255, 0, 2'b00);
        for (int i = 0; i < 4; i++) step2(1, 0, 40);
        eu[0]++;
        check_all("max_up", 0, 0, 255, 0, 2'b00);
        for (int i = 0; i < 4; i++) step2(0, -1, 40);
        ed[1]++;
        check_all("min_down", 0, 255, 255, 0, 2'b00);

        for (int i = 0; i < 4; i++) step2(1, 1, 40);
        eu[0]++; eu[1]++;
        check_all("both_ch", 1, 0, 255, 1, 2'b00);
        for (int i = 0; i < 4; i++) step2(1, -1, 40);
        eu[0]++; ed[1]++;
        check_all("opposite", 2, 255, 255, 0, 2'b00);

        step2(1, 0, 40);
        step2(1, 0, 40);
        step2(2, 0, 40);
        check_all("jump", 2, 255, 255, 0, 2'b01);
        err_clr = 2'b01; wait_cyc(1); err_clr = 2'b00; wait_cyc(2);
        check_all("err_clr", 2, 255, 255, 0, 2'b00);

        // Illegal jump reaches the decoder on the 19th edge; err_clr lands on that edge
        step2(2, 0, 0);
        wait_cyc(18);
        err_clr = 2'b01; wait_cyc(1); err_clr = 2'b00;
        wait_cyc(10);
        check_all("set_wins", 2, 255, 255, 0, 2'b01);
        err_clr = 2'b01; wait_cyc(1); err_clr = 2'b00; wait_cyc(2);
        check_all("err_clr2", 2, 255, 255, 0, 2'b00);

        for (int i = 0; i < 3; i++) step2(1, 0, 40);
        check_all("post_err", 2, 255, 255, 0, 2'b00);

        // Fourth step: pulse register loads on the 20th edge, clr applied on that edge
        step2(1, 0, 0);
        wait_cyc(19);
        clr = 2'b01; wait_cyc(1); clr = 2'b00;
        wait_cyc(20);
        eu[0]++;
        check_all("clr_pulse", 0, 255, 0, 0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
